zd_phase_driver: RTL and testbench

// Initiator side of the zero_detector interface. Accepts operand pairs over a valid/ready

---
 rtl/zd_phase_driver_if.sv | 29 ++
 rtl/zd_phase_driver.sv | 200 ++++++++++++++++++++
 tb/tb_zd_phase_driver.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zd_phase_driver_if.sv
// ---------------------------------------------------------------------------
// zd_phase_driver_if
// Operand and result handshake bundle between a compare requester and
// zd_phase_driver.
//   in_valid / in_ready / in_a / in_b : operand pair launch handshake
//   res_valid / res_ready / res_eq    : compare result return handshake
// master = requester side, slave = zd_phase_driver side.
// ---------------------------------------------------------------------------
interface zd_phase_driver_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic             res_eq;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_eq
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_eq
    );
endinterface

// File: rtl/zd_phase_driver.sv
// ---------------------------------------------------------------------------
// zd_phase_driver
// Initiator for the adiabatic zero_detector compare path. Accepts operand
// pairs, drives them onto the detector, generates the 7-stage 4-phase power
// clocks and returns the sampled equality result through a small FIFO.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   enable_i       : run request for the phase clocks
//   bus            : operand/result handshakes (zd_phase_driver_if.slave)
//   a_drv_o/b_drv_o: operands held on the detector inputs
//   clkpos_o[0:6]  : per-stage positive power clock
//   clkneg_o[0:6]  : per-stage negative power clock (always ~clkpos_o)
//   dut_out_i      : detector output
//   busy_o         : clocks running or results in flight / buffered
// ---------------------------------------------------------------------------
module zd_phase_driver #(
    parameter int WIDTH     = 16,
    parameter int QTR_TICKS = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    zd_phase_driver_if.slave bus,
    output logic [WIDTH-1:0] a_drv_o,
    output logic [WIDTH-1:0] b_drv_o,
    output logic [0:6]       clkpos_o,
    output logic [0:6]       clkneg_o,
    input  logic             dut_out_i,
    output logic             busy_o
);
    localparam int TW = (QTR_TICKS > 1) ? $clog2(QTR_TICKS) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(QTR_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(RES_DEPTH);
    localparam logic [OW-1:0] CREDIT    = OW'(RES_DEPTH);

    // Stage k is high while (q - k) mod 4 is 0 or 1; the 2-bit subtraction wraps mod 4.
    function automatic logic [0:6] stage_clocks(input logic run, input logic [1:0] q);
        logic [0:6] pat;
        logic [1:0] ph;
        pat = 7'b0000000;
        for (int k = 0; k < 7; k++) begin
            ph     = q - 2'(k);
            pat[k] = run && (ph < 2'd2);
        end
        return pat;
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    logic [TW-1:0]        tick_q, tick_d;
    logic [1:0]           q_q, q_d;
    logic                 run_q, run_d;
    logic [1:0]           launch_q, launch_d;
    logic [RES_DEPTH-1:0] fifo_q, fifo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_drv_q, a_drv_d;
    logic [WIDTH-1:0]     b_drv_q, b_drv_d;
    logic [0:6]           clkpos_q, clkneg_q;
    logic                 res_valid_q;
    logic                 busy_q;

    logic                 period_end_s;
    logic [1:0]           inflight_s;
    logic [OW-1:0]        outstanding_s;
    logic                 in_ready_s;
    logic                 hs_s;
    logic                 push_s;
    logic                 pop_s;
    logic [RES_DEPTH-1:0] shifted_s;
    logic                 full_s;

    // Handshake, credit and sampling decisions, all from registered state.
    always_comb begin
        period_end_s  = run_q && (tick_q == TICK_LAST) && (q_q == 2'd3);
        inflight_s    = popcount2(launch_q);
        // Credit counts every launch not yet popped: in the pipe plus buffered.
        outstanding_s = OW'(inflight_s) + OW'(cnt_q);
        in_ready_s    = period_end_s && enable_i && (outstanding_s < CREDIT);
        hs_s          = bus.in_valid && in_ready_s;
        // A launch two period ends ago is in stage 6 hold now.
        push_s        = period_end_s && launch_q[1];
        pop_s         = res_valid_q && bus.res_ready;
        full_s        = (cnt_q == CNT_FULL);
    end

    // Quarter timebase and run control.
    always_comb begin
        tick_d = tick_q;
        q_d    = q_q;
        run_d  = run_q;
        if (!run_q) begin
            run_d  = enable_i;
            tick_d = '0;
            q_d    = 2'd0;
        end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            q_d    = q_q + 2'd1;
            // Stopping is only allowed once the pipe has drained.
            if (period_end_s && !enable_i && (inflight_s == 2'd0)) begin
                run_d = 1'b0;
            end else begin
                run_d = 1'b1;
            end
        end else begin
            tick_d = tick_q + TICK_ONE;
        end
    end

    // Launch tracking, operand capture and result FIFO next state.
    always_comb begin
        int wr_idx;
        launch_d  = period_end_s ? {launch_q[0], hs_s} : launch_q;
        a_drv_d   = hs_s ? bus.in_a : a_drv_q;
        b_drv_d   = hs_s ? bus.in_b : b_drv_q;
        // Shift FIFO: entry 0 is the head, a pop shifts everything down first.
        shifted_s = pop_s ? (fifo_q >> 1) : fifo_q;
        wr_idx    = pop_s ? (int'(cnt_q) - 1) : int'(cnt_q);
        fifo_d    = shifted_s;
        for (int i = 0; i < RES_DEPTH; i++) begin
            if (push_s && (i == wr_idx)) begin
                fifo_d[i] = dut_out_i;
            end else begin
                fifo_d[i] = shifted_s[i];
            end
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; clocks, valid and busy are registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q      <= '0;
            q_q         <= 2'd0;
            run_q       <= 1'b0;
            launch_q    <= 2'b00;
            fifo_q      <= '0;
            cnt_q       <= '0;
            a_drv_q     <= '0;
            b_drv_q     <= '0;
            clkpos_q    <= 7'b0000000;
            clkneg_q    <= 7'b1111111;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            q_q         <= q_d;
            run_q       <= run_d;
            launch_q    <= launch_d;
            fifo_q      <= fifo_d;
            cnt_q       <= cnt_d;
            a_drv_q     <= a_drv_d;
            b_drv_q     <= b_drv_d;
            clkpos_q    <= stage_clocks(run_d, q_d);
            clkneg_q    <= ~stage_clocks(run_d, q_d);
            res_valid_q <= (cnt_d != '0);
            busy_q      <= run_d || (launch_d != 2'b00) || (cnt_d != '0);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.res_valid = res_valid_q;
    assign bus.res_eq    = fifo_q[0];
    assign a_drv_o       = a_drv_q;
    assign b_drv_o       = b_drv_q;
    assign clkpos_o      = clkpos_q;
    assign clkneg_o      = clkneg_q;
    assign busy_o        = busy_q;

    zd_phase_driver_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push_s),
        .full_i (full_s)
    );
endmodule

// ---------------------------------------------------------------------------
// zd_phase_driver_chk
// Property checker: the launch credit must make a push into a full result
// buffer impossible.
// ---------------------------------------------------------------------------
module zd_phase_driver_chk (
    input logic clk,
    input logic rst_n,
    input logic push_i,
    input logic full_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i));
endmodule

// File: tb/tb_zd_phase_driver.sv
module tb_zd_phase_driver;
    localparam int WIDTH = 16;
    localparam int QT    = 4;
    localparam int DEPTH = 2;
    localparam int PER   = 4 * QT;
    localparam int DLY   = 24;   // detector delay, lands inside the launch's hold window
    localparam int LIMIT = 600;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             dut_out;
    logic [WIDTH-1:0] a_drv, b_drv;
    logic [0:6]       clkpos, clkneg;
    logic             busy;
    logic [DLY-1:0]   hist = '0;

    zd_phase_driver_if #(.WIDTH(WIDTH)) bus_if ();

    zd_phase_driver #(.WIDTH(WIDTH), .QTR_TICKS(QT), .RES_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable),
        .bus       (bus_if),
        .a_drv_o   (a_drv),
        .b_drv_o   (b_drv),
        .clkpos_o  (clkpos),
        .clkneg_o  (clkneg),
        .dut_out_i (dut_out),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // Detector stand-in: equality of the driven operands, delayed by DLY cycles.
    always @(posedge clk) hist <= {hist[DLY-2:0], (a_drv == b_drv)};
    assign dut_out = hist[DLY-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   cyc = 0;
    bit   m_run = 1'b0;
    int   m_c = 0;         // cycles since the clocks started
    int   fifo_cnt = 0;    // results sampled but not popped
    int   lq[$];           // period index of each launch still in the pipe
    bit   exp_q[$];        // scoreboard: expected res_eq in launch order
    int   hs_cyc = 0;

    function automatic bit m_period_end();
        return m_run && ((m_c % PER) == PER - 1);
    endfunction

    function automatic bit m_in_ready();
        return m_period_end() && enable && ((lq.size() + fifo_cnt) < DEPTH);
    endfunction

    function automatic logic [0:6] m_clk();
        logic [0:6] pat;
        int qq;
        pat = 7'b0000000;
        qq  = (m_c / QT) % 4;
        for (int k = 0; k < 7; k++) pat[k] = m_run && ((((qq - k) % 4 + 4) % 4) < 2);
        return pat;
    endfunction

    always @(posedge clk) begin : model
        bit pe, rdy, hs, pop;
        int inflight_pre, p;
        cyc++;
        if (!rst_n) begin
            m_run = 1'b0; m_c = 0; fifo_cnt = 0;
            lq.delete(); exp_q.delete();
        end else begin
            pe  = m_period_end();
            rdy = m_in_ready();
            hs  = bus_if.in_valid && rdy;
            pop = (fifo_cnt > 0) && bus_if.res_ready;
            if (pop) fifo_cnt--;
            if (pe) begin
                p = m_c / PER;
                inflight_pre = lq.size();
                if (lq.size() > 0 && lq[0] == p - 2) begin
                    void'(lq.pop_front());
                    fifo_cnt++;
                end
                if (hs) begin
                    lq.push_back(p);
                    exp_q.push_back(bus_if.in_a == bus_if.in_b);
                    hs_cyc = cyc;
                end
                if (!enable && inflight_pre == 0) begin
                    m_run = 1'b0; m_c = 0;
                end else begin
                    m_c++;
                end
            end else if (m_run) begin
                m_c++;
            end else if (enable) begin
                m_run = 1'b1; m_c = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [0:6] prev_pos = 7'b0000000;
    int         rise_cyc[7];
    bit         rise_ok[7];

    always @(negedge clk) begin : monitor
        logic [0:6] ec, inv;
        ec  = m_clk();
        inv = ~clkpos;
        check("clkpos", {25'b0, clkpos}, {25'b0, ec});
        check("clkneg_inv", {25'b0, clkneg}, {25'b0, inv});
        check("in_ready", {31'b0, bus_if.in_ready}, {31'b0, m_in_ready()});
        check("res_valid", {31'b0, bus_if.res_valid}, {31'b0, fifo_cnt > 0});
        check("busy", {31'b0, busy}, {31'b0, (m_run || lq.size() != 0 || fifo_cnt != 0)});
        if (bus_if.res_valid && bus_if.res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_result: got res_eq %0b expected no result", bus_if.res_eq);
            end else begin
                check("res_eq", {31'b0, bus_if.res_eq}, {31'b0, exp_q.pop_front()});
            end
        end
        if (clkpos == 7'b0000000) begin
            for (int k = 0; k < 7; k++) rise_ok[k] = 1'b0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (clkpos[k] && !prev_pos[k]) begin
                    if (k > 0 && rise_ok[k-1] && prev_pos != 7'b0000000)
                        check("phase_lag", cyc - rise_cyc[k-1], QT);
                    rise_cyc[k] = cyc;
                    rise_ok[k]  = 1'b1;
                end
            end
        end
        prev_pos = clkpos;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!bus_if.in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected one within %0d cycles", LIMIT);
        end
        @(posedge clk);
        #2;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus_if.in_a = a;
        bus_if.in_b = b;
        bus_if.in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || lq.size() != 0 || fifo_cnt != 0) && n < LIMIT) begin
            step(1);
            n++;
        end
        if (n >= LIMIT) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    bit rnd_done = 1'b0;

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int n;
        bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0; bus_if.res_ready = 1'b0;
        step(3);
        check("rst_a_drv", {16'b0, a_drv}, 32'h0);
        check("rst_b_drv", {16'b0, b_drv}, 32'h0);
        check("rst_res_eq", {31'b0, bus_if.res_eq}, 32'h0);
        rst_n = 1'b1;

        // single compare and its latency
        enable = 1'b1; bus_if.res_ready = 1'b1;
        send(16'h1234, 16'h1234);
        n = 0;
        while (!bus_if.res_valid && n < 100) begin @(negedge clk); n++; end
        check("latency", cyc - hs_cyc, 8 * QT);
        check("first_eq", {31'b0, bus_if.res_eq}, 32'h1);
        wait_idle();

        // back-to-back launches
        send(16'h0000, 16'h0000);
        send(16'h8000, 16'h0000);
        send(16'hFFFF, 16'hFFFF);
        wait_idle();

        // result back-pressure blocks the third launch
        bus_if.res_ready = 1'b0;
        send(16'h0101, 16'h0101);
        send(16'h0202, 16'h0203);
        bus_if.in_a = 16'h0303; bus_if.in_b = 16'h0303; bus_if.in_valid = 1'b1;
        repeat (6 * PER) begin
            @(negedge clk);
            check("bp_blocked", {31'b0, bus_if.in_ready}, 32'h0);
        end
        @(posedge clk); #2;
        bus_if.res_ready = 1'b1;
        wait_accept();
        wait_idle();

        // enable drop with two in flight
        bus_if.res_ready = 1'b0;
        send(16'h00AA, 16'h00AA);
        send(16'h00AA, 16'h00AB);
        enable = 1'b0;
        n = 0;
        while (m_run && n < LIMIT) begin step(1); n++; end
        @(negedge clk);
        check("drain_clkpos", {25'b0, clkpos}, 32'h0);
        check("drain_busy", {31'b0, busy}, 32'h1);
        check("drain_count", fifo_cnt, 2);
        step(1);
        bus_if.res_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("drain_idle_busy", {31'b0, busy}, 32'h0);
        step(1);

        // reset mid-period with two in flight
        enable = 1'b1;
        send(16'h5555, 16'h5555);
        send(16'h6666, 16'h6666);
        step(5);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        check("mid_rst_clkpos", {25'b0, clkpos}, 32'h0);
        check("mid_rst_clkneg", {25'b0, clkneg}, 32'h7F);
        check("mid_rst_valid", {31'b0, bus_if.res_valid}, 32'h0);
        step(1);
        rst_n = 1'b1;

        // randomized traffic with random result back-pressure
        fork
            begin
                for (int t = 0; t < 30; t++) begin
                    ra = 16'($urandom);
                    case ($urandom_range(0, 2))
                        0:       rb = ra;
                        1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                        default: rb = 16'($urandom);
                    endcase
                    send(ra, rb);
                    step($urandom_range(0, 20));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2;
                    bus_if.res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus_if.res_ready = 1'b1;
        wait_idle();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
